// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared sizes, FSM state type and cell slicing for the display refresh controller
package display_pkg;

  localparam int NUM_CHARS = 32;
  localparam int CHAR_W    = 8;
  localparam int IDX_W     = $clog2(NUM_CHARS);
  localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SCAN,
    WAIT_ACK
  } state_e;

  function automatic logic [CHAR_W-1:0] cell_slice(
    input logic [NUM_CHARS*CHAR_W-1:0] bufv,
    input logic [IDX_W-1:0]            idx
  );
    return bufv[idx*CHAR_W +: CHAR_W];
  endfunction

endpackage

// File: rtl/display_shadow_mem.sv
// rtl/display_shadow_mem.sv - shadow of the characters the LCD shows, with per-cell valid bits
module display_shadow_mem
  import display_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_all_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [CHAR_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [CHAR_W-1:0] rd_data_i,
  output logic              dirty_o
);

  logic [CHAR_W-1:0]    shown_q [NUM_CHARS];
  logic [NUM_CHARS-1:0] valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_CHARS; i++) shown_q[i] <= BLANK_CHAR;
    end else if (clr_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
      if (wr_valid_i) shown_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign dirty_o = !valid_q[rd_idx_i] || (shown_q[rd_idx_i] != rd_data_i);

endmodule

// File: rtl/display_refresh_ctrl.sv
// rtl/display_refresh_ctrl.sv - waits for a stable display buffer, then writes only changed cells to the LCD
module display_refresh_ctrl
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int ACK_TIMEOUT   = 65535
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic [NUM_CHARS*CHAR_W-1:0] disp_buf,
  input  logic                        force_refresh,
  output logic                        char_req,
  output logic [IDX_W-1:0]            char_addr,
  output logic [CHAR_W-1:0]           char_data,
  input  logic                        char_ack,
  output logic                        busy,
  output logic                        ack_err
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  state_e                      state_q;
  logic [NUM_CHARS*CHAR_W-1:0] snap_q;
  logic [IDX_W-1:0]            idx_q;
  logic [SET_W-1:0]            settle_cnt_q;
  logic [TO_W-1:0]             to_cnt_q;
  logic                        force_pend_q;
  logic                        char_req_q;
  logic [IDX_W-1:0]            char_addr_q;
  logic [CHAR_W-1:0]           char_data_q;
  logic                        busy_q;
  logic                        ack_err_q;

  logic              buf_changed;
  logic              last_cell;
  logic              to_hit;
  logic              xfer_done;
  logic              clr_all;
  logic              dirty;
  logic [CHAR_W-1:0] cur_char;

  assign buf_changed = (disp_buf != snap_q);
  assign last_cell   = (idx_q == IDX_W'(NUM_CHARS - 1));
  assign to_hit      = (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));
  // An ack arriving on the timeout cycle still counts as a successful write.
  assign xfer_done   = (state_q == WAIT_ACK) && (char_ack || to_hit);
  assign clr_all     = (state_q == IDLE) && force_pend_q;
  assign cur_char    = cell_slice(snap_q, idx_q);

  display_shadow_mem u_shadow (
    .clk_i      (clk),
    .rst_i      (RESET),
    .clr_all_i  (clr_all),
    .wr_en_i    (xfer_done),
    .wr_idx_i   (idx_q),
    .wr_data_i  (char_data_q),
    .wr_valid_i (char_ack),
    .rd_idx_i   (idx_q),
    .rd_data_i  (cur_char),
    .dirty_o    (dirty)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
      force_pend_q <= 1'b1;
      char_req_q   <= 1'b0;
      char_addr_q  <= '0;
      char_data_q  <= BLANK_CHAR;
      busy_q       <= 1'b0;
      ack_err_q    <= 1'b0;
    end else begin
      if (force_refresh) force_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (buf_changed || force_pend_q) begin
            snap_q       <= disp_buf;
            settle_cnt_q <= '0;
            state_q      <= SETTLE;
            busy_q       <= 1'b1;
            // A fresh force pulse on this edge must survive the clear.
            force_pend_q <= force_refresh;
          end
        end
        SETTLE: begin
          if (buf_changed) begin
            snap_q       <= disp_buf;
            settle_cnt_q <= '0;
          end else if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
            idx_q   <= '0;
            state_q <= SCAN;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        SCAN: begin
          if (dirty) begin
            char_addr_q <= idx_q;
            char_data_q <= cur_char;
            char_req_q  <= 1'b1;
            to_cnt_q    <= '0;
            state_q     <= WAIT_ACK;
          end else if (last_cell) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (xfer_done) begin
            char_req_q <= 1'b0;
            if (!char_ack) ack_err_q <= 1'b1;
            if (last_cell) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= SCAN;
            end
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char_req  = char_req_q;
  assign char_addr = char_addr_q;
  assign char_data = char_data_q;
  assign busy      = busy_q;
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// tb/tb_display_refresh_ctrl.sv - scoreboard bench for display_refresh_ctrl
module tb_display_refresh_ctrl;

  localparam int NC = 32;

  logic            clk = 1'b0;
  logic            RESET;
  logic [NC*8-1:0] disp_buf;
  logic            force_refresh;
  logic            char_req;
  logic [4:0]      char_addr;
  logic [7:0]      char_data;
  logic            char_ack;
  logic            busy;
  logic            ack_err;

  display_refresh_ctrl #(.SETTLE_CYCLES(4), .ACK_TIMEOUT(16)) dut (
    .clk           (clk),
    .RESET         (RESET),
    .disp_buf      (disp_buf),
    .force_refresh (force_refresh),
    .char_req      (char_req),
    .char_addr     (char_addr),
    .char_data     (char_data),
    .char_ack      (char_ack),
    .busy          (busy),
    .ack_err       (ack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [12:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int n_req = 0;
  int last_rise = 0;
  int noack_addr = -1;
  bit abort = 1'b0;
  bit seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cell(input int i, input logic [7:0] v);
    disp_buf[i*8 +: 8] = v;
  endtask

  task automatic push_cell(input int i);
    exp_q.push_back({i[4:0], disp_buf[i*8 +: 8]});
  endtask

  task automatic push_all();
    for (int i = 0; i < NC; i++) push_cell(i);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(exp_q.size() == 0 && !busy && !char_req) && k < budget);
    check_eq("idle_reached", {busy, char_req, exp_q.size() != 0}, 0);
  endtask

  task automatic wait_req_addr(input int a, input int budget);
    int k;
    k = 0;
    while (!(char_req && int'(char_addr) == a) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("req_addr_seen", {char_req, char_addr}, {1'b1, a[4:0]});
  endtask

  // LCD driver model: checks each request against the scoreboard and acks one cycle later.
  initial begin : responder
    logic [12:0] e;
    char_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (char_req && !seen) begin
        seen = 1'b1;
        last_rise = cyc;
        n_req++;
        check_eq("sb_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("req_addr", char_addr, e[12:8]);
          check_eq("req_data", char_data, e[7:0]);
        end
        if (int'(char_addr) != noack_addr) begin
          @(negedge clk);
          char_ack = 1'b1;
          @(negedge clk);
          char_ack = 1'b0;
          check_eq("req_drop", char_req, 0);
          seen = 1'b0;
        end
      end else if (!char_req && seen) begin
        seen = 1'b0;
        if (!abort) check_eq("timeout_len", cyc - last_rise, 16);
      end
    end
  end

  initial begin : main
    int k;
    int t0;
    int r;
    disp_buf = {NC{8'h41}};
    RESET = 1'b1;
    force_refresh = 1'b0;
    tick(2);
    check_eq("rst_req", char_req, 0);
    check_eq("rst_addr", char_addr, 0);
    check_eq("rst_data", char_data, 8'h20);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ackerr", ack_err, 0);

    // Full redraw after reset, then busy timing after the last request.
    push_all();
    @(negedge clk);
    RESET = 1'b0;
    k = 0;
    while (n_req < 32 && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("s1_nreq", n_req, 32);
    r = last_rise;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("s1_busy_fall", cyc - r, 2);
    wait_idle(100);
    check_eq("s1_ackerr", ack_err, 0);

    // Single cell change latency.
    tick(3);
    set_cell(5, 8'h5A);
    push_cell(5);
    t0 = cyc;
    wait_idle(200);
    check_eq("s2_latency", last_rise - t0, 11);

    // Bouncing cell must not be sent until it holds still.
    tick(3);
    for (int i = 0; i < 10; i++) begin
      set_cell(3, (i % 2 == 1) ? 8'h31 : 8'h30);
      tick(2);
    end
    set_cell(3, 8'h33);
    push_cell(3);
    t0 = cyc;
    wait_idle(200);
    check_eq("s3_latency", last_rise - t0, 9);

    // Change during an in-flight request is picked up by a second pass.
    tick(3);
    set_cell(10, 8'h44);
    push_cell(10);
    wait_req_addr(10, 100);
    set_cell(20, 8'h39);
    push_cell(20);
    wait_idle(300);
    check_eq("s4_ackerr", ack_err, 0);

    // Ack timeout on cell 0; other cells still go, cell 0 retried next pass.
    tick(3);
    noack_addr = 0;
    set_cell(0, 8'h30);
    set_cell(7, 8'h37);
    push_cell(0);
    push_cell(7);
    wait_idle(300);
    check_eq("s5_ackerr_set", ack_err, 1);
    noack_addr = -1;
    tick(3);
    set_cell(9, 8'h39);
    push_cell(0);
    push_cell(9);
    wait_idle(300);
    check_eq("s5_ackerr_sticky", ack_err, 1);

    // Forced redraw with an unchanged buffer.
    tick(3);
    force_refresh = 1'b1;
    tick(1);
    force_refresh = 1'b0;
    push_all();
    wait_idle(500);
    check_eq("s6_ackerr_sticky", ack_err, 1);

    // Asynchronous reset while a request is outstanding.
    tick(3);
    noack_addr = 12;
    force_refresh = 1'b1;
    tick(1);
    force_refresh = 1'b0;
    push_all();
    wait_req_addr(12, 300);
    exp_q.delete();
    abort = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    check_eq("s6_req_async", char_req, 0);
    check_eq("s6_busy_async", busy, 0);
    tick(2);
    check_eq("s6_ackerr_clr", ack_err, 0);
    check_eq("s6_data_rst", char_data, 8'h20);
    noack_addr = -1;
    push_all();
    @(negedge clk);
    RESET = 1'b0;
    wait_idle(500);
    abort = 1'b0;

    tick(30);
    check_eq("final_q_empty", exp_q.size(), 0);
    check_eq("final_nreq", n_req, 117);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
